// File: rtl/gpu_cmd_dispatcher.sv
// GPU command dispatcher: pops one command at a time from a show-ahead FIFO,
// broadcasts the latched fields to all drawing engines and strobes the target.
// Per-engine busy tracking gates issue; FENCE drains every engine before the
// next command is fetched.
module gpu_cmd_dispatcher #(
  parameter int unsigned NUM_ENGINES   = 2,
  parameter int unsigned WIDTH_BITS    = 10,
  parameter int unsigned HEIGHT_BITS   = 9,
  parameter int unsigned CHANNEL_BITS  = 8,
  parameter int unsigned ALLOW_OVERLAP = 0,
  parameter int unsigned COUNT_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic [NUM_ENGINES-1:0]  finished_i,
  output logic                    pop_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [NUM_ENGINES-1:0]  run_o,
  output logic [NUM_ENGINES-1:0]  busy_o,
  output logic                    idle_o,
  output logic                    err_o,
  output logic [COUNT_BITS-1:0]   cmd_count_o
);

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpFence = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StWait,
    StIssue,
    StFence
  } state_e;

  state_e                  state_q;
  logic [3:0]              opcode_q;
  logic [NUM_ENGINES-1:0]  busy_q;
  logic [COUNT_BITS-1:0]   cmd_count_q;
  logic                    err_q;
  logic [NUM_ENGINES-1:0]  tgt_mask;
  logic                    tgt_ready;

  // One-hot target engine from the latched opcode; all-zero for NOP/FENCE/illegal.
  always_comb begin
    tgt_mask = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      tgt_mask[i] = (opcode_q == 4'(i + 1));
    end
  end

  // Serial mode waits for every engine; overlap mode only for the target.
  assign tgt_ready = (ALLOW_OVERLAP != 0) ? ((busy_q & tgt_mask) == '0) : (busy_q == '0);

  // Dispatch FSM, busy tracking, field latch, counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      opcode_q    <= OpNop;
      busy_q      <= '0;
      cmd_count_q <= '0;
      err_q       <= 1'b0;
      x1_o        <= '0;
      y1_o        <= '0;
      x2_o        <= '0;
      y2_o        <= '0;
      rad_o       <= '0;
      r_o         <= '0;
      g_o         <= '0;
      b_o         <= '0;
    end else begin
      // Finish pulses for idle engines fall out of the mask naturally.
      busy_q <= (busy_q & ~finished_i) | ((state_q == StIssue) ? tgt_mask : '0);
      case (state_q)
        StIdle: begin
          if (!fifo_empty_i) state_q <= StFetch;
        end
        StFetch: begin
          opcode_q <= opcode_i;
          x1_o     <= x1_i;
          y1_o     <= y1_i;
          x2_o     <= x2_i;
          y2_o     <= y2_i;
          rad_o    <= rad_i;
          r_o      <= r_i;
          g_o      <= g_i;
          b_o      <= b_i;
          state_q  <= StDecode;
        end
        StDecode: begin
          if (opcode_q == OpNop) begin
            state_q <= StIdle;
          end else if (opcode_q == OpFence) begin
            state_q <= StFence;
          end else if (|tgt_mask) begin
            state_q <= tgt_ready ? StIssue : StWait;
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (tgt_ready) state_q <= StIssue;
        end
        StIssue: begin
          cmd_count_q <= cmd_count_q + COUNT_BITS'(1);
          state_q     <= StIdle;
        end
        StFence: begin
          if (busy_q == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pop_o       = (state_q == StFetch);
  assign run_o       = (state_q == StIssue) ? tgt_mask : '0;
  assign busy_o      = busy_q;
  assign idle_o      = (state_q == StIdle) && (busy_q == '0);
  assign err_o       = err_q;
  assign cmd_count_o = cmd_count_q;

endmodule

// File: tb/tb_gpu_cmd_dispatcher.sv
// Bench for gpu_cmd_dispatcher: dut 0 runs serial dispatch, dut 1 overlapped.
// Stimulus pushes commands into a FIFO model and expected issues into a
// scoreboard; a negedge monitor pops and compares on every run_o strobe.
module tb_gpu_cmd_dispatcher;

  typedef struct packed {
    logic [3:0] op;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [9:0] x2;
    logic [8:0] y2;
    logic [9:0] rad;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } cmd_t;

  typedef struct {
    int          dut;
    logic [1:0]  run;
    cmd_t        c;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  cmd_t       mem [2][16];
  logic [3:0] wr [2];
  logic [3:0] rd [2];
  bit         pend [2];
  int         pops [2];
  bit         dbl_busy = 1'b0;
  bit         pop_empty = 1'b0;
  exp_t       sb [$];
  exp_t       mon_e;

  cmd_t                  head [2];
  logic [1:0]            fifo_empty;
  logic [1:0][1:0]       fin;
  logic [1:0]            pop_o;
  logic [1:0][9:0]       x1_o, x2_o, rad_o;
  logic [1:0][8:0]       y1_o, y2_o;
  logic [1:0][7:0]       r_o, g_o, b_o;
  logic [1:0][1:0]       run_o, busy_o;
  logic [1:0]            idle_o, err_o;
  logic [1:0][15:0]      cnt_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign head[0]       = mem[0][rd[0]];
  assign head[1]       = mem[1][rd[1]];
  assign fifo_empty[0] = (rd[0] == wr[0]);
  assign fifo_empty[1] = (rd[1] == wr[1]);

  gpu_cmd_dispatcher #(.ALLOW_OVERLAP(0)) u_ser (
    .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty[0]), .opcode_i(head[0].op),
    .x1_i(head[0].x1), .y1_i(head[0].y1), .x2_i(head[0].x2), .y2_i(head[0].y2),
    .rad_i(head[0].rad), .r_i(head[0].r), .g_i(head[0].g), .b_i(head[0].b),
    .finished_i(fin[0]), .pop_o(pop_o[0]), .x1_o(x1_o[0]), .y1_o(y1_o[0]),
    .x2_o(x2_o[0]), .y2_o(y2_o[0]), .rad_o(rad_o[0]), .r_o(r_o[0]), .g_o(g_o[0]),
    .b_o(b_o[0]), .run_o(run_o[0]), .busy_o(busy_o[0]), .idle_o(idle_o[0]),
    .err_o(err_o[0]), .cmd_count_o(cnt_o[0])
  );

  gpu_cmd_dispatcher #(.ALLOW_OVERLAP(1)) u_ovl (
    .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty[1]), .opcode_i(head[1].op),
    .x1_i(head[1].x1), .y1_i(head[1].y1), .x2_i(head[1].x2), .y2_i(head[1].y2),
    .rad_i(head[1].rad), .r_i(head[1].r), .g_i(head[1].g), .b_i(head[1].b),
    .finished_i(fin[1]), .pop_o(pop_o[1]), .x1_o(x1_o[1]), .y1_o(y1_o[1]),
    .x2_o(x2_o[1]), .y2_o(y2_o[1]), .rad_o(rad_o[1]), .r_o(r_o[1]), .g_o(g_o[1]),
    .b_o(b_o[1]), .run_o(run_o[1]), .busy_o(busy_o[1]), .idle_o(idle_o[1]),
    .err_o(err_o[1]), .cmd_count_o(cnt_o[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [3:0] op, input int k);
    cmd_t c;
    c.op  = op;
    c.x1  = 10'(k * 7 + 1);
    c.y1  = 9'(k * 5 + 2);
    c.x2  = 10'(k * 11 + 3);
    c.y2  = 9'(k * 13 + 4);
    c.rad = 10'(k * 3 + 5);
    c.r   = 8'(k + 6);
    c.g   = 8'(k + 7);
    c.b   = 8'(k + 8);
    return c;
  endfunction

  task automatic push(input int d, input cmd_t c);
    mem[d][wr[d]] = c;
    wr[d] = wr[d] + 4'd1;
  endtask

  task automatic expect_run(input int d, input logic [1:0] run, input cmd_t c,
                            input logic [15:0] cnt, input int at);
    exp_t e;
    e.dut = d; e.run = run; e.c = c; e.cnt = cnt; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic chk_reset_state(input int d);
    chk($sformatf("rst_pop%0d", d), pop_o[d], 1'b0);
    chk($sformatf("rst_run%0d", d), run_o[d], 2'b00);
    chk($sformatf("rst_busy%0d", d), busy_o[d], 2'b00);
    chk($sformatf("rst_idle%0d", d), idle_o[d], 1'b1);
    chk($sformatf("rst_err%0d", d), err_o[d], 1'b0);
    chk($sformatf("rst_count%0d", d), cnt_o[d], 16'd0);
    chk($sformatf("rst_fields%0d", d), {x1_o[d], y1_o[d], x2_o[d], y2_o[d], rad_o[d],
                                        r_o[d], g_o[d], b_o[d]}, 128'd0);
  endtask

  // FIFO model: the entry is retired the negedge after pop_o so the DUT latches it first.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rd[d]   = wr[d];
        pend[d] = 1'b0;
      end else begin
        if (pop_o[d] && fifo_empty[d]) pop_empty = 1'b1;
        if (pend[d] && rd[d] != wr[d]) begin
          rd[d] = rd[d] + 4'd1;
          pops[d]++;
        end
        pend[d] = pop_o[d];
      end
    end
  end

  // Scoreboard monitor: every run_o strobe must match the next expected issue.
  always @(negedge clk) begin
    if (busy_o[0] == 2'b11) dbl_busy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (!rst && run_o[d] != 2'b00) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_run dut%0d: got run %b at cycle %0d, required none",
                   d, run_o[d], cyc);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("issue_dut@%0d", cyc), d, mon_e.dut);
          chk($sformatf("issue_run@%0d", cyc), run_o[d], mon_e.run);
          chk($sformatf("issue_fields@%0d", cyc),
              {x1_o[d], y1_o[d], x2_o[d], y2_o[d], rad_o[d], r_o[d], g_o[d], b_o[d]},
              {mon_e.c.x1, mon_e.c.y1, mon_e.c.x2, mon_e.c.y2, mon_e.c.rad,
               mon_e.c.r, mon_e.c.g, mon_e.c.b});
          chk($sformatf("issue_count@%0d", cyc), cnt_o[d], mon_e.cnt);
          chk($sformatf("issue_cycle@%0d", cyc), cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish within 10000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int p0;
    cmd_t ca, cb, cc;
    wr[0] = '0; wr[1] = '0;
    fin = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state(0);
    chk_reset_state(1);

    // Single dispatch on the serial instance.
    @(negedge clk);
    n = cyc;
    ca = '{op: 4'd1, x1: 10'd15, y1: 9'd150, x2: 10'd299, y2: 9'd250, rad: 10'd0,
           r: 8'd10, g: 8'd9, b: 8'd8};
    push(0, ca);
    expect_run(0, 2'b01, ca, 16'd0, n + 3);
    @(negedge clk); chk("single_pop_n+1", pop_o[0], 1'b1);
    @(negedge clk); chk("single_pop_n+2", pop_o[0], 1'b0);
    repeat (2) @(negedge clk);
    chk("single_busy", busy_o[0], 2'b01);
    chk("single_count", cnt_o[0], 16'd1);
    chk("single_idle_busy", idle_o[0], 1'b0);
    repeat (3) @(negedge clk);
    chk("single_busy_held", busy_o[0], 2'b01);
    fin[0] = 2'b01;
    @(negedge clk); fin[0] = 2'b00;
    chk("single_busy_clr", busy_o[0], 2'b00);
    chk("single_idle", idle_o[0], 1'b1);

    // Serial mode: engine 1 command waits for engine 0 to drain.
    @(negedge clk);
    n = cyc;
    ca = mk(4'd1, 1); cb = mk(4'd2, 2);
    push(0, ca); push(0, cb);
    expect_run(0, 2'b01, ca, 16'd1, n + 3);
    expect_run(0, 2'b10, cb, 16'd2, n + 12);
    repeat (10) @(negedge clk);
    chk("serial_wait_busy", busy_o[0], 2'b01);
    fin[0] = 2'b01;
    @(negedge clk); fin[0] = 2'b00;
    chk("serial_busy_clr", busy_o[0], 2'b00);
    repeat (2) @(negedge clk);
    chk("serial_busy_b", busy_o[0], 2'b10);
    chk("serial_count", cnt_o[0], 16'd3);
    fin[0] = 2'b10;
    @(negedge clk); fin[0] = 2'b00;
    chk("serial_drained", busy_o[0], 2'b00);

    // Overlap mode: 1,2 back-to-back, third waits on engine 0.
    @(negedge clk);
    n = cyc;
    ca = mk(4'd1, 3); cb = mk(4'd2, 4); cc = mk(4'd1, 5);
    push(1, ca); push(1, cb); push(1, cc);
    expect_run(1, 2'b01, ca, 16'd0, n + 3);
    expect_run(1, 2'b10, cb, 16'd1, n + 7);
    expect_run(1, 2'b01, cc, 16'd2, n + 16);
    repeat (8) @(negedge clk);
    chk("overlap_busy11", busy_o[1], 2'b11);
    repeat (6) @(negedge clk);
    fin[1] = 2'b01;
    @(negedge clk); fin[1] = 2'b00;
    repeat (2) @(negedge clk);
    chk("overlap_busy_c", busy_o[1], 2'b11);
    chk("overlap_count", cnt_o[1], 16'd3);
    fin[1] = 2'b11;
    @(negedge clk); fin[1] = 2'b00;
    chk("overlap_dual_finish", busy_o[1], 2'b00);

    // Reset mid-WAIT with engine 0 busy.
    @(negedge clk);
    n = cyc;
    ca = mk(4'd1, 6); cb = mk(4'd2, 7);
    push(0, ca); push(0, cb);
    expect_run(0, 2'b01, ca, 16'd3, n + 3);
    repeat (8) @(negedge clk);
    chk("prereset_busy", busy_o[0], 2'b01);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_state(0);
    chk_reset_state(1);
    repeat (10) @(negedge clk);
    chk("postreset_busy", busy_o[0], 2'b00);

    // FENCE on the overlap instance holds the next pop until engine 0 drains.
    @(negedge clk);
    n = cyc;
    p0 = pops[1];
    ca = mk(4'd1, 8); cc = mk(4'hF, 9); cb = mk(4'd2, 10);
    push(1, ca); push(1, cc); push(1, cb);
    expect_run(1, 2'b01, ca, 16'd0, n + 3);
    expect_run(1, 2'b10, cb, 16'd1, n + 17);
    repeat (12) @(negedge clk);
    chk("fence_holds_pop", pops[1] - p0, 2);
    chk("fence_busy", busy_o[1], 2'b01);
    fin[1] = 2'b01;
    @(negedge clk); fin[1] = 2'b00;
    repeat (5) @(negedge clk);
    chk("fence_count", cnt_o[1], 16'd2);
    chk("fence_pops", pops[1] - p0, 3);
    fin[1] = 2'b10;
    @(negedge clk); fin[1] = 2'b00;

    // NOP and illegal opcode, then a legal command.
    @(negedge clk);
    n = cyc;
    p0 = pops[0];
    ca = mk(4'd0, 11); cc = mk(4'd7, 12); cb = mk(4'd1, 13);
    push(0, ca); push(0, cc); push(0, cb);
    expect_run(0, 2'b01, cb, 16'd0, n + 9);
    repeat (5) @(negedge clk);
    chk("illegal_err_before", err_o[0], 1'b0);
    @(negedge clk);
    chk("illegal_err_set", err_o[0], 1'b1);
    repeat (5) @(negedge clk);
    chk("illegal_count", cnt_o[0], 16'd1);
    chk("illegal_err_sticky", err_o[0], 1'b1);
    chk("illegal_pops", pops[0] - p0, 3);
    fin[0] = 2'b01;
    @(negedge clk); fin[0] = 2'b00;
    chk("illegal_busy_clr", busy_o[0], 2'b00);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("serial_two_busy", dbl_busy, 1'b0);
    chk("pop_while_empty", pop_empty, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
